// File: rtl/cp_gpp_pkg.sv
// Shared types and constants for the CP/GPP bridge.
package cp_gpp_pkg;

    localparam int unsigned WORD_W        = 16;
    localparam int unsigned DEPTH_DEFAULT = 8;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/cp_gpp_if.sv
// GPP and network handshake signals of the bridge; slave = bridge side, master = environment.
interface cp_gpp_if;
    import cp_gpp_pkg::*;

    word_t gpp_tx_data;
    logic  gpp_trf_cp;
    logic  gpp_rx_read;
    word_t RAM_rx_data_out;
    logic  data_rx_flag;
    logic  tx_overflow;
    word_t net_tx_data;
    logic  net_tx_valid;
    logic  net_tx_ready;
    word_t net_rx_data;
    logic  net_rx_valid;
    logic  net_rx_ready;

    modport slave (
        input  gpp_tx_data, gpp_trf_cp, gpp_rx_read, net_tx_ready, net_rx_data, net_rx_valid,
        output RAM_rx_data_out, data_rx_flag, tx_overflow, net_tx_data, net_tx_valid,
               net_rx_ready
    );

    modport master (
        output gpp_tx_data, gpp_trf_cp, gpp_rx_read, net_tx_ready, net_rx_data, net_rx_valid,
        input  RAM_rx_data_out, data_rx_flag, tx_overflow, net_tx_data, net_tx_valid,
               net_rx_ready
    );

endinterface

// File: rtl/word_fifo.sv
// First-word-fall-through word FIFO; head reads as zero when empty.
module word_fifo
    import cp_gpp_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  word_t                    din_i,
    output word_t                    dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    word_t             mem_q [DEPTH];
    logic [PtrW-1:0]   wptr_q, wptr_d;
    logic [PtrW-1:0]   rptr_q, rptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign count_o = cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) begin
            mem_q[wptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/cp_gpp_bridge.sv
// GPP <-> network bridge: TX and RX word FIFOs with sticky TX overflow.
// Optional internal loopback (TX head -> RX) when CP_LOOPBACK_EN is defined.
module cp_gpp_bridge
    import cp_gpp_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input logic      clk,
    input logic      rst,
`ifdef CP_LOOPBACK_EN
    input logic      loopback_en,
`endif
    cp_gpp_if.slave  bus
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic            tx_push, tx_pop, tx_full, tx_empty;
    logic            rx_push, rx_pop, rx_full, rx_empty;
    logic [CntW-1:0] tx_count, rx_count;
    word_t           tx_head, rx_head, rx_din;
    logic            tx_overflow_d, tx_overflow_q;

    always_comb begin
`ifdef CP_LOOPBACK_EN
        tx_pop  = !tx_empty && (loopback_en ? !rx_full : bus.net_tx_ready);
        rx_push = loopback_en ? tx_pop : (bus.net_rx_valid && !rx_full);
        rx_din  = loopback_en ? tx_head : bus.net_rx_data;
`else
        tx_pop  = !tx_empty && bus.net_tx_ready;
        rx_push = bus.net_rx_valid && !rx_full;
        rx_din  = bus.net_rx_data;
`endif
        tx_push       = bus.gpp_trf_cp && (!tx_full || tx_pop);
        rx_pop        = bus.gpp_rx_read && !rx_empty;
        tx_overflow_d = tx_overflow_q || (bus.gpp_trf_cp && tx_full && !tx_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow_q <= 1'b0;
        end else begin
            tx_overflow_q <= tx_overflow_d;
        end
    end

    word_fifo #(
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (tx_push),
        .pop_i   (tx_pop),
        .din_i   (bus.gpp_tx_data),
        .dout_o  (tx_head),
        .count_o (tx_count),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    word_fifo #(
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (rx_push),
        .pop_i   (rx_pop),
        .din_i   (rx_din),
        .dout_o  (rx_head),
        .count_o (rx_count),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign bus.net_tx_data     = tx_head;
    assign bus.RAM_rx_data_out = rx_head;
    assign bus.data_rx_flag    = (rx_count != '0);
    assign bus.tx_overflow     = tx_overflow_q;
`ifdef CP_LOOPBACK_EN
    assign bus.net_tx_valid = (tx_count != '0) && !loopback_en;
    assign bus.net_rx_ready = !rx_full && !rst && !loopback_en;
`else
    assign bus.net_tx_valid = (tx_count != '0);
    assign bus.net_rx_ready = !rx_full && !rst;
`endif

endmodule

// File: tb/tb_cp_gpp_bridge.sv
// Bench for cp_gpp_bridge: vector table, directed corner sequences, random traffic vs queue model.
module tb_cp_gpp_bridge;
    import cp_gpp_pkg::*;

    localparam int unsigned D = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lb  = 1'b0;
    int   checks = 0;
    int   errors = 0;

    word_t txq[$];
    word_t rxq[$];
    bit    ovf = 1'b0;

    cp_gpp_if bus ();

    cp_gpp_bridge #(
        .DEPTH (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef CP_LOOPBACK_EN
        .loopback_en (lb),
`endif
        .bus         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  rst, trf;
        word_t txd;
        logic  rxrd, txrdy;
        word_t rxd;
        logic  rxv;
        logic  e_txv;
        word_t e_txd;
        logic  e_flag;
        word_t e_rxd;
        logic  e_ovf, e_rdy;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic r, logic t, word_t td, logic rr, logic tr, word_t rd,
                                logic rv, logic etv, word_t etd, logic ef, word_t erd,
                                logic eo, logic ey);
        vec_t v;
        v.rst = r; v.trf = t; v.txd = td; v.rxrd = rr; v.txrdy = tr; v.rxd = rd; v.rxv = rv;
        v.e_txv = etv; v.e_txd = etd; v.e_flag = ef; v.e_rxd = erd; v.e_ovf = eo; v.e_rdy = ey;
        return v;
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic r, logic t, word_t td, logic rr, logic tr, word_t rd, logic rv);
        rst              = r;
        bus.gpp_trf_cp   = t;
        bus.gpp_tx_data  = td;
        bus.gpp_rx_read  = rr;
        bus.net_tx_ready = tr;
        bus.net_rx_data  = rd;
        bus.net_rx_valid = rv;
    endtask

    // Reference behaviour of one clock edge, from the currently driven inputs.
    task automatic model_edge();
        bit    tpop, tpush, rpop, rpush;
        word_t head;
        if (rst) begin
            txq.delete();
            rxq.delete();
            ovf = 1'b0;
            return;
        end
        head  = (txq.size() > 0) ? txq[0] : 16'h0000;
        tpop  = (txq.size() > 0) && (lb ? (rxq.size() < D) : bus.net_tx_ready);
        tpush = bus.gpp_trf_cp && ((txq.size() < D) || tpop);
        if (bus.gpp_trf_cp && !tpush) ovf = 1'b1;
        rpop  = bus.gpp_rx_read && (rxq.size() > 0);
        rpush = lb ? tpop : (bus.net_rx_valid && (rxq.size() < D));
        if (tpop) void'(txq.pop_front());
        if (tpush) txq.push_back(bus.gpp_tx_data);
        if (rpop) void'(rxq.pop_front());
        if (rpush) rxq.push_back(lb ? head : bus.net_rx_data);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("net_tx_valid", 16'(bus.net_tx_valid), 16'((txq.size() > 0) && !lb));
        check("net_tx_data", bus.net_tx_data, (txq.size() > 0) ? txq[0] : 16'h0000);
        check("data_rx_flag", 16'(bus.data_rx_flag), 16'(rxq.size() > 0));
        check("RAM_rx_data_out", bus.RAM_rx_data_out, (rxq.size() > 0) ? rxq[0] : 16'h0000);
        check("tx_overflow", 16'(bus.tx_overflow), 16'(ovf));
        check("net_rx_ready", 16'(bus.net_rx_ready), 16'((rxq.size() < D) && !rst && !lb));
        check("tx_count", 16'(dut.u_tx_fifo.count_o), 16'(txq.size()));
        check("rx_count", 16'(dut.u_rx_fifo.count_o), 16'(rxq.size()));
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);

        vecs[0]  = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 1, 16'h0011, 0, 1, 16'h0000, 0, 1, 16'h0011, 0, 16'h0000, 0, 1);
        vecs[2]  = mk(0, 1, 16'h0022, 0, 1, 16'h0000, 0, 1, 16'h0022, 0, 16'h0000, 0, 1);
        vecs[3]  = mk(0, 1, 16'h0033, 0, 1, 16'h0000, 0, 1, 16'h0033, 0, 16'h0000, 0, 1);
        vecs[4]  = mk(0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1);
        vecs[5]  = mk(0, 0, 16'h0000, 0, 0, 16'hBEEF, 1, 0, 16'h0000, 1, 16'hBEEF, 0, 1);
        vecs[6]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1);
        vecs[7]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1);
        vecs[8]  = mk(0, 1, 16'h0A0A, 0, 0, 16'h5555, 1, 1, 16'h0A0A, 1, 16'h5555, 0, 1);
        vecs[9]  = mk(0, 1, 16'h0B0B, 0, 0, 16'h6666, 1, 1, 16'h0A0A, 1, 16'h5555, 0, 1);
        vecs[10] = mk(0, 1, 16'h0C0C, 0, 0, 16'h0000, 0, 1, 16'h0A0A, 1, 16'h5555, 0, 1);
        vecs[11] = mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 0);
        vecs[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0, 1);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].trf, vecs[i].txd, vecs[i].rxrd, vecs[i].txrdy,
                  vecs[i].rxd, vecs[i].rxv);
            step();
            check($sformatf("vec%0d.txv", i), 16'(bus.net_tx_valid), 16'(vecs[i].e_txv));
            check($sformatf("vec%0d.txd", i), bus.net_tx_data, vecs[i].e_txd);
            check($sformatf("vec%0d.flag", i), 16'(bus.data_rx_flag), 16'(vecs[i].e_flag));
            check($sformatf("vec%0d.rxd", i), bus.RAM_rx_data_out, vecs[i].e_rxd);
            check($sformatf("vec%0d.ovf", i), 16'(bus.tx_overflow), 16'(vecs[i].e_ovf));
            check($sformatf("vec%0d.rdy", i), 16'(bus.net_rx_ready), 16'(vecs[i].e_rdy));
        end

        // Overflow: nine pushes into a stalled TX FIFO, ninth word must vanish.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
            step();
        end
        check("ovf_count", 16'(dut.u_tx_fifo.count_o), 16'd8);
        check("ovf_flag", 16'(bus.tx_overflow), 16'd1);
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_head", bus.net_tx_data, 16'h0100 + 16'(i));
            drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0);
            step();
        end
        check("ovf_drained", 16'(bus.net_tx_valid), 16'd0);
        check("ovf_sticky", 16'(bus.tx_overflow), 16'd1);

        // Full TX with simultaneous push and pop must not overflow.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
            step();
        end
        drive(1'b0, 1'b1, 16'h02FF, 1'b0, 1'b1, 16'h0, 1'b0);
        step();
        check("full_pp_count", 16'(dut.u_tx_fifo.count_o), 16'd8);
        check("full_pp_ovf", 16'(bus.tx_overflow), 16'd0);
        check("full_pp_head", bus.net_tx_data, 16'h0201);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 7; i++) step();
        check("full_pp_last", bus.net_tx_data, 16'h02FF);

`ifdef CP_LOOPBACK_EN
        do_reset();
        lb = 1'b1;
        drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h0, 1'b0);
        step();
        check("lb_txv0", 16'(bus.net_tx_valid), 16'd0);
        check("lb_flag0", 16'(bus.data_rx_flag), 16'd0);
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0, 1'b0);
        step();
        check("lb_txv1", 16'(bus.net_tx_valid), 16'd0);
        check("lb_rx_head", bus.RAM_rx_data_out, 16'h1234);
        lb = 1'b0;
`endif

        // Random traffic; first half biases toward a stalled network to exercise full FIFOs.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
`ifdef CP_LOOPBACK_EN
            if (n % 64 == 0) lb = ($urandom_range(0, 3) == 0);
`endif
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 9) < 6),
                  16'($urandom),
                  (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1),
                  (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1),
                  16'($urandom),
                  ($urandom_range(0, 9) < 6));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
